// File: rtl/error_acc_pkg.sv
// Shared types and defaults for the SSE / max-abs error accumulator.
package error_acc_pkg;

    localparam int unsigned DEF_DATA_W    = 20;
    localparam int unsigned DEF_FRAC_W    = 10;
    localparam int unsigned DEF_N_SAMPLES = 150;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_ACC_W     = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest positive value of a w-bit two's complement number (w <= 32).
    function automatic logic [31:0] abs_sat_max(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/error_square_stage.sv
// Pipeline stage 1: saturating absolute value and its square, registered.
module error_square_stage
    import error_acc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     err_in,
    output logic [DATA_W-1:0]     abs,
    output logic [2*DATA_W-1:0]   sq,
    output logic                  valid_out
);

    localparam logic [DATA_W-1:0] ABS_MAX  = DATA_W'(abs_sat_max(DATA_W));
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0]   w_abs;
    logic [2*DATA_W-1:0] w_sq;
    logic [DATA_W-1:0]   r_abs;
    logic [2*DATA_W-1:0] r_sq;
    logic                r_valid;

    // |err_in| with the most negative code clamped, then squared
    always_comb begin
        w_abs = err_in;
        if (err_in == MOST_NEG) begin
            w_abs = ABS_MAX;
        end else if (err_in[DATA_W-1]) begin
            w_abs = -err_in;
        end
        w_sq = (2*DATA_W)'(w_abs) * (2*DATA_W)'(w_abs);
    end

    // Stage register; payload only loads on a valid sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_abs   <= '0;
            r_sq    <= '0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_abs <= w_abs;
                r_sq  <= w_sq;
            end
        end
    end

    assign abs       = r_abs;
    assign sq        = r_sq;
    assign valid_out = r_valid;

endmodule

// File: rtl/error_accumulator.sv
// Run-level accumulator: sum of squared residuals and max |residual| over N samples.
module error_accumulator
    import error_acc_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FRAC_W    = DEF_FRAC_W,
    parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned ACC_W     = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               err_valid,
    input  logic [DATA_W-1:0]  err_in,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   sse,
    output logic [DATA_W-1:0]  max_abs_err,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic               sse_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [ACC_W-1:0] SSE_MAX  = '1;

    // Elaboration-time parameter sanity
    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $error("FRAC_W must be smaller than DATA_W");
    end
    if (ACC_W < 2*DATA_W) begin : g_bad_acc
        $error("ACC_W must hold at least one full square");
    end
    if ((2**CNT_W) <= N_SAMPLES) begin : g_bad_cnt
        $error("CNT_W too narrow for N_SAMPLES");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_last;
    logic                w_clear;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                r_busy;
    logic                r_done;
    logic [ACC_W-1:0]    r_sse;
    logic [DATA_W-1:0]   r_max;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [DATA_W-1:0]   w_abs;
    logic [2*DATA_W-1:0] w_sq;
    logic                w_sq_valid;
    logic [ACC_W:0]      w_sum;

    assign w_accept = (r_state == ACCUM) && err_valid;
    assign w_last   = w_accept && (r_cnt == LAST_CNT);
    assign w_clear  = (r_state == IDLE) && start;

    // Residuals only enter the pipe while accumulating
    error_square_stage #(
        .DATA_W (DATA_W)
    ) u_square (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (w_accept),
        .err_in    (err_in),
        .abs       (w_abs),
        .sq        (w_sq),
        .valid_out (w_sq_valid)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = ACCUM;
            ACCUM:   if (w_last) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode, taken from the next state so the flops line up with it
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ACCUM:   w_busy_nxt = 1'b1;
            FLUSH:   w_busy_nxt = 1'b1;
            DONE:    w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign w_sum = (ACC_W+1)'(r_sse) + (ACC_W+1)'(w_sq);

    // Stage 2: saturating SSE, running max and sample count
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_sse <= '0;
            r_max <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_sq_valid) begin
                if (w_sum[ACC_W]) begin
                    r_sse <= SSE_MAX;
                    r_ovf <= 1'b1;
                end else begin
                    r_sse <= w_sum[ACC_W-1:0];
                end
                if (w_abs > r_max) begin
                    r_max <= w_abs;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign sse         = r_sse;
    assign max_abs_err = r_max;
    assign sample_cnt  = r_cnt;
    assign sse_ovf     = r_ovf;

endmodule

// File: tb/tb_error_accumulator.sv
// Bench for error_accumulator: four instances share one stimulus stream.
module tb_error_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        err_valid;
    logic [19:0] err_in;

    always #5 clk = ~clk;

    logic b0, d0, o0, b1, d1, o1, b2, d2, o2, b3, d3, o3;
    logic [7:0]  c0, c1, c2, c3;
    logic [19:0] m0, m1, m2, m3;
    logic [47:0] s0, s1, s2;
    logic [39:0] s3;

    error_accumulator u_dut0 (
        .clk(clk), .rst(rst), .start(start), .err_valid(err_valid), .err_in(err_in),
        .busy(b0), .done(d0), .sse(s0), .max_abs_err(m0), .sample_cnt(c0), .sse_ovf(o0));
    error_accumulator #(.N_SAMPLES(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .err_valid(err_valid), .err_in(err_in),
        .busy(b1), .done(d1), .sse(s1), .max_abs_err(m1), .sample_cnt(c1), .sse_ovf(o1));
    error_accumulator #(.N_SAMPLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .err_valid(err_valid), .err_in(err_in),
        .busy(b2), .done(d2), .sse(s2), .max_abs_err(m2), .sample_cnt(c2), .sse_ovf(o2));
    error_accumulator #(.ACC_W(40), .N_SAMPLES(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .err_valid(err_valid), .err_in(err_in),
        .busy(b3), .done(d3), .sse(s3), .max_abs_err(m3), .sample_cnt(c3), .sse_ovf(o3));

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        ovf;
        logic [7:0]  cnt;
        logic [19:0] mx;
        logic [47:0] sse;
    } obs_t;

    typedef struct {
        int          res;
        logic [63:0] exp_max;
        logic [63:0] exp_sse;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int q_res[$];

    function automatic obs_t obs(input int k);
        obs_t o;
        case (k)
            0:       o = {b0, d0, o0, c0, m0, s0};
            1:       o = {b1, d1, o1, c1, m1, s1};
            2:       o = {b2, d2, o2, c2, m2, s2};
            3:       o = {b3, d3, o3, c3, m3, 8'd0, s3};
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference: run results straight from the arithmetic definition
    function automatic void model(input int accw, output logic [63:0] e_sse,
                                  output logic [63:0] e_max, output logic e_ovf);
        longint unsigned lim, s, a, m;
        lim = (64'd1 << accw) - 64'd1;
        s = 0; m = 0; e_ovf = 1'b0;
        foreach (q_res[i]) begin
            a = 64'((q_res[i] < 0) ? -q_res[i] : q_res[i]);
            if (a > 524287) a = 524287;
            s = s + a * a;
            if (s > lim) begin
                s = lim;
                e_ovf = 1'b1;
            end
            if (a > m) m = a;
        end
        e_sse = s;
        e_max = m;
    endfunction

    // Start a run on instance k, feed q_res with gaps, check the done timing and results
    task automatic run_seq(input int k, input string tag, input int gap_max,
                           input bit rand_gap, input bit do_rst);
        obs_t        o;
        bit          bad;
        int          g;
        logic [63:0] e_sse, e_max;
        logic        e_ovf;
        model((k == 3) ? 40 : 48, e_sse, e_max, e_ovf);
        if (do_rst) rst_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        o = obs(k);
        chk({tag, " busy after start"}, 64'(o.busy), 64'd1);
        chk({tag, " cleared sse"}, 64'(o.sse), 64'd0);
        chk({tag, " cleared ovf"}, 64'(o.ovf), 64'd0);
        bad = 1'b0;
        foreach (q_res[i]) begin
            g = rand_gap ? int'($urandom_range(0, gap_max)) : gap_max;
            repeat (g) begin
                tick();
                o = obs(k);
                if (o.done || !o.busy) bad = 1'b1;
            end
            err_valid = 1'b1;
            err_in    = 20'(q_res[i]);
            tick();
            err_valid = 1'b0;
            err_in    = 20'($urandom);
            o = obs(k);
            if (o.done || !o.busy) bad = 1'b1;
        end
        chk({tag, " busy/done during run"}, 64'(bad), 64'd0);
        chk({tag, " flush cnt"}, 64'(o.cnt), 64'(q_res.size()));
        tick();
        o = obs(k);
        chk({tag, " done pulse"}, 64'(o.done), 64'd1);
        chk({tag, " busy low at done"}, 64'(o.busy), 64'd0);
        chk({tag, " sse"}, 64'(o.sse), e_sse);
        chk({tag, " max"}, 64'(o.mx), e_max);
        chk({tag, " ovf"}, 64'(o.ovf), 64'(e_ovf));
        tick();
        o = obs(k);
        chk({tag, " done one cycle"}, 64'(o.done), 64'd0);
    endtask

    vec_t tbl[7];

    initial begin
        obs_t             o;
        int               v;
        int               n_done;
        logic signed [19:0] t;

        tbl[0] = '{-524288, 64'd524287, 64'd274876858369};
        tbl[1] = '{ 524287, 64'd524287, 64'd274876858369};
        tbl[2] = '{      0, 64'd0,      64'd0};
        tbl[3] = '{   1024, 64'd1024,   64'd1048576};
        tbl[4] = '{  -1024, 64'd1024,   64'd1048576};
        tbl[5] = '{     -1, 64'd1,      64'd1};
        tbl[6] = '{   -513, 64'd513,    64'd263169};

        rst = 1'b1; start = 1'b0; err_valid = 1'b0; err_in = '0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            o = obs(k);
            chk("reset busy", 64'(o.busy), 64'd0);
            chk("reset done", 64'(o.done), 64'd0);
            chk("reset sse", 64'(o.sse), 64'd0);
            chk("reset cnt", 64'(o.cnt), 64'd0);
            chk("reset max", 64'(o.mx), 64'd0);
            chk("reset ovf", 64'(o.ovf), 64'd0);
        end
        rst = 1'b0;

        // Unit residuals, back to back and gapped
        q_res = '{1024, -1024, 512, 0};
        run_seq(1, "unit", 0, 1'b0, 1'b1);
        chk("unit sse const", 64'(s1), 64'd2359296);
        chk("unit max const", 64'(m1), 64'd1024);
        chk("unit cnt const", 64'(c1), 64'd4);
        run_seq(1, "gap", 3, 1'b0, 1'b1);
        chk("gap sse const", 64'(s1), 64'd2359296);
        chk("gap max const", 64'(m1), 64'd1024);

        // err_valid in IDLE is ignored and results hold
        err_valid = 1'b1; err_in = 20'd7;
        repeat (3) tick();
        err_valid = 1'b0;
        chk("idle valid cnt", 64'(c1), 64'd4);
        chk("idle valid sse", 64'(s1), 64'd2359296);

        // Single-sample runs from the vector table
        for (int i = 0; i < 7; i++) begin
            q_res = '{tbl[i].res};
            run_seq(2, "tbl", 0, 1'b0, 1'b1);
            chk("tbl sse", 64'(s2), tbl[i].exp_sse);
            chk("tbl max", 64'(m2), tbl[i].exp_max);
            chk("tbl ovf", 64'(o2), 64'd0);
        end

        // Saturation with a 40-bit accumulator, then a clean run clears the flag
        q_res = {};
        repeat (8) q_res.push_back(-524288);
        run_seq(3, "sat", 0, 1'b0, 1'b1);
        chk("sat sse const", 64'(s3), 64'hFF_FFFF_FFFF);
        chk("sat ovf const", 64'(o3), 64'd1);
        q_res = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_seq(3, "sat_clr", 0, 1'b0, 1'b0);
        chk("sat_clr sse const", 64'(s3), 64'd204);

        // Protocol abuse on the N=4 instance
        rst_pulse();
        start = 1'b1; tick(); start = 1'b0;
        err_valid = 1'b1; err_in = 20'd1024; tick();
        err_in = 20'd2048; tick();
        err_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("abuse mid start busy", 64'(b1), 64'd1);
        chk("abuse mid start cnt", 64'(c1), 64'd2);
        chk("abuse mid start sse", 64'(s1), 64'd5242880);
        err_valid = 1'b1; err_in = 20'd3; tick();
        err_in = 20'(-5); tick();
        err_valid = 1'b0;
        tick();
        chk("abuse done", 64'(d1), 64'd1);
        chk("abuse sse", 64'(s1), 64'd5242914);
        chk("abuse max", 64'(m1), 64'd2048);
        start = 1'b1; err_valid = 1'b1; err_in = 20'd100; tick();
        err_valid = 1'b0;
        chk("abuse start in done busy", 64'(b1), 64'd0);
        chk("abuse valid in done cnt", 64'(c1), 64'd4);
        chk("abuse start in done sse", 64'(s1), 64'd5242914);
        tick();
        start = 1'b0;
        chk("abuse late start busy", 64'(b1), 64'd1);
        chk("abuse late start cnt", 64'(c1), 64'd0);
        chk("abuse late start sse", 64'(s1), 64'd0);
        chk("abuse late start max", 64'(m1), 64'd0);

        // Reset mid-run on the N=150 instance
        rst_pulse();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            err_valid = 1'b1; err_in = 20'(100 * (i + 1)); tick();
        end
        err_valid = 1'b0;
        chk("midrst cnt before", 64'(c0), 64'd5);
        rst_pulse();
        chk("midrst busy", 64'(b0), 64'd0);
        chk("midrst sse", 64'(s0), 64'd0);
        chk("midrst max", 64'(m0), 64'd0);
        chk("midrst cnt", 64'(c0), 64'd0);
        n_done = 0;
        repeat (6) begin
            tick();
            if (d0) n_done++;
        end
        chk("midrst no done", 64'(n_done), 64'd0);

        // Randomized full-length runs against the reference model
        for (int r = 0; r < 3; r++) begin
            q_res = {};
            for (int i = 0; i < 150; i++) begin
                case ($urandom_range(0, 9))
                    0:       v = -524288;
                    1:       v = 524287;
                    2:       v = int'($urandom_range(0, 2047)) - 1024;
                    default: begin t = 20'($urandom); v = int'(t); end
                endcase
                q_res.push_back(v);
            end
            run_seq(0, "rnd", 2, 1'b1, (r != 0));
            chk("rnd cnt", 64'(c0), 64'd150);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
